fetch_ctrl: RTL and testbench

//  Sequencer for the instruction-fetch stage. Drives the PC write and next-PC value, the instruction-memory request

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_timeout_ctr.sv | 40 ++++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STALL = 3'd3,
    ST_ERROR = 3'd4
  } fetch_state_t;

  // Sequential next PC; wraps at 2^32 and leaves PC[1:0] untouched.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive unacknowledged request cycles; flags the cycle that reaches TIMEOUT.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_max_c;

  assign at_max_c = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose increment lands on TIMEOUT, so the FSM can leave on that edge.
  assign expired = at_max_c || (inc && (cnt_q == CW'(TIMEOUT - 1)));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC update, IMEM request handshake and IF/ID write/flush control.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        EX_MEM_PCSrc,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        ID_STALL,
  input  logic        IMEM_ACK,
  output logic        IMEM_REQ,
  output logic        PC_WE,
  output logic [31:0] PC_NEXT,
  output logic        IF_ID_WE,
  output logic        IF_ID_FLUSH,
  output logic        FETCH_ERR
);

  fetch_state_t    state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  logic            imem_req_c;
  logic            expired_c;
  logic            pc_we_c;
  logic [PC_W-1:0] pc_next_c;
  logic            if_id_we_c;
  logic            if_id_flush_c;

  assign imem_req_c = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (imem_req_c && !IMEM_ACK),
    .clr     (imem_req_c && IMEM_ACK),
    .expired (expired_c)
  );

  // Next-state, pending-redirect update and Mealy enables.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    pc_we_c       = 1'b0;
    pc_next_c     = RESET_PC;
    if_id_we_c    = 1'b0;
    if_id_flush_c = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        // Gated by RST so every enable reads 0 while reset is held.
        pc_we_c = RST;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (expired_c) begin
          state_d = ST_ERROR;
        end else if (IMEM_ACK) begin
          if (EX_MEM_PCSrc) begin
            if_id_flush_c = 1'b1;
            pc_we_c       = 1'b1;
            pc_next_c     = EX_MEM_NPC;
          end else if (ID_STALL) begin
            state_d = ST_STALL;
          end else begin
            if_id_we_c = 1'b1;
            pc_we_c    = 1'b1;
            pc_next_c  = pc_incr(PC);
          end
        end else if (EX_MEM_PCSrc) begin
          if_id_flush_c = 1'b1;
          pend_pc_d     = EX_MEM_NPC;
          pend_valid_d  = 1'b1;
          state_d       = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The outstanding request cannot be cancelled; its data is dropped on ACK.
        if (expired_c) begin
          state_d = ST_ERROR;
        end else begin
          if_id_flush_c = EX_MEM_PCSrc;
          if (IMEM_ACK) begin
            pc_we_c      = 1'b1;
            pc_next_c    = EX_MEM_PCSrc ? EX_MEM_NPC : (pend_valid_q ? pend_pc_q : PC);
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end else if (EX_MEM_PCSrc) begin
            pend_pc_d    = EX_MEM_NPC;
            pend_valid_d = 1'b1;
          end
        end
      end

      ST_STALL: begin
        if (EX_MEM_PCSrc) begin
          if_id_flush_c = 1'b1;
          pc_we_c       = 1'b1;
          pc_next_c     = EX_MEM_NPC;
          state_d       = ST_FETCH;
        end else if (!ID_STALL) begin
          if_id_we_c = 1'b1;
          pc_we_c    = 1'b1;
          pc_next_c  = pc_incr(PC);
          state_d    = ST_FETCH;
        end
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_BOOT;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign IMEM_REQ    = imem_req_c;
  assign PC_WE       = pc_we_c;
  assign PC_NEXT     = pc_next_c;
  assign IF_ID_WE    = if_id_we_c;
  assign IF_ID_FLUSH = if_id_flush_c;
  assign FETCH_ERR   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table through a scoreboard queue, plus timeout/reset sequences.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TO     = 15;

  typedef struct packed {
    logic        req;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        if_id_we;
    logic        flush;
    logic        err;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic        src;
    logic [31:0] npc;
    logic        stall;
    logic        ack;
    out_t        exp;
    out_t        mask;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] PC = '0;
  logic        EX_MEM_PCSrc = 1'b0;
  logic [31:0] EX_MEM_NPC = '0;
  logic        ID_STALL = 1'b0;
  logic        IMEM_ACK = 1'b0;
  logic        IMEM_REQ, PC_WE, IF_ID_WE, IF_ID_FLUSH, FETCH_ERR;
  logic [31:0] PC_NEXT;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   exp_q[$];

  fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC          (PC),
    .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .EX_MEM_NPC  (EX_MEM_NPC),
    .ID_STALL    (ID_STALL),
    .IMEM_ACK    (IMEM_ACK),
    .IMEM_REQ    (IMEM_REQ),
    .PC_WE       (PC_WE),
    .PC_NEXT     (PC_NEXT),
    .IF_ID_WE    (IF_ID_WE),
    .IF_ID_FLUSH (IF_ID_FLUSH),
    .FETCH_ERR   (FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic out_t o(logic req, logic we, logic [31:0] nxt, logic ifid, logic fl, logic err);
    return {req, we, nxt, ifid, fl, err};
  endfunction

  // PC_NEXT is only meaningful when PC_WE=1 or while reset is held.
  function automatic vec_t mkv(string name, logic rst, logic [31:0] pc, logic src, logic [31:0] npc,
                               logic stall, logic ack, out_t exp, logic dc_fl);
    vec_t v;
    v.name = name; v.rst = rst; v.pc = pc; v.src = src; v.npc = npc;
    v.stall = stall; v.ack = ack; v.exp = exp;
    v.mask = '1;
    if (rst && !exp.pc_we) v.mask.pc_next = '0;
    if (dc_fl) v.mask.flush = 1'b0;
    return v;
  endfunction

  task automatic check_out(input vec_t v);
    out_t got;
    got = {IMEM_REQ, PC_WE, PC_NEXT, IF_ID_WE, IF_ID_FLUSH, FETCH_ERR};
    n_tests++;
    if (((got ^ v.exp) & v.mask) !== '0) begin
      n_fail++;
      $display("FAIL %s: got req=%0b we=%0b next=%h ifid=%0b flush=%0b err=%0b, expected req=%0b we=%0b next=%h ifid=%0b flush=%0b err=%0b",
               v.name, got.req, got.pc_we, got.pc_next, got.if_id_we, got.flush, got.err,
               v.exp.req, v.exp.pc_we, v.exp.pc_next, v.exp.if_id_we, v.exp.flush, v.exp.err);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(posedge CLK);
    #1;
    RST = v.rst; PC = v.pc; EX_MEM_PCSrc = v.src; EX_MEM_NPC = v.npc;
    ID_STALL = v.stall; IMEM_ACK = v.ack;
    sb_q.push_back(v);
    @(negedge CLK);
    check_out(sb_q.pop_front());
  endtask

  initial begin
    int req_cycles;
    bit hit;

    // Reset held, then release with ACK tied high.
    vecs.push_back(mkv("reset_hold",   0, 32'h0,   0, 32'h0,   0, 1, o(0,0,RST_PC,0,0,0), 0));
    vecs.push_back(mkv("boot",         1, 32'h0,   0, 32'h0,   0, 1, o(0,1,RST_PC,0,0,0), 0));
    vecs.push_back(mkv("seq_4",        1, 32'h0,   0, 32'h0,   0, 1, o(1,1,32'h4,1,0,0), 0));
    vecs.push_back(mkv("seq_8",        1, 32'h4,   0, 32'h0,   0, 1, o(1,1,32'h8,1,0,0), 0));
    vecs.push_back(mkv("seq_c",        1, 32'h8,   0, 32'h0,   0, 1, o(1,1,32'hC,1,0,0), 0));
    // Redirect in the first wait cycle, ACK after three waits.
    vecs.push_back(mkv("redir_wait1",  1, 32'hC,   1, 32'h100, 0, 0, o(1,0,0,0,1,0), 0));
    vecs.push_back(mkv("drain_wait2",  1, 32'hC,   0, 32'h0,   0, 0, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("drain_wait3",  1, 32'hC,   0, 32'h0,   0, 0, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("drain_ack",    1, 32'hC,   0, 32'h0,   0, 1, o(1,1,32'h100,0,0,0), 0));
    // Two redirects while draining: newest wins.
    vecs.push_back(mkv("redir_200",    1, 32'h100, 1, 32'h200, 0, 0, o(1,0,0,0,1,0), 0));
    vecs.push_back(mkv("drain_idle",   1, 32'h100, 0, 32'h0,   0, 0, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("redir_300",    1, 32'h100, 1, 32'h300, 0, 0, o(1,0,0,0,1,0), 0));
    vecs.push_back(mkv("drain_ack300", 1, 32'h100, 0, 32'h0,   0, 1, o(1,1,32'h300,0,0,0), 0));
    // ACK with redirect and stall together: flush wins, stays in FETCH.
    vecs.push_back(mkv("ack_redir",    1, 32'h300, 1, 32'h400, 1, 1, o(1,1,32'h400,0,1,0), 0));
    // Redirect arriving on the draining ACK overrides the pending target.
    vecs.push_back(mkv("redir_500",    1, 32'h400, 1, 32'h500, 0, 0, o(1,0,0,0,1,0), 0));
    vecs.push_back(mkv("drain_ack600", 1, 32'h400, 1, 32'h600, 0, 1, o(1,1,32'h600,0,0,0), 1));
    // Load-use stall for two cycles.
    vecs.push_back(mkv("stall_enter",  1, 32'h600, 0, 32'h0,   1, 1, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("stall_hold",   1, 32'h600, 0, 32'h0,   1, 0, o(0,0,0,0,0,0), 0));
    vecs.push_back(mkv("stall_exit",   1, 32'h600, 0, 32'h0,   0, 0, o(0,1,32'h604,1,0,0), 0));
    // Redirect during STALL.
    vecs.push_back(mkv("stall_enter2", 1, 32'h604, 0, 32'h0,   1, 1, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("stall_redir",  1, 32'h604, 1, 32'h700, 1, 0, o(0,1,32'h700,0,1,0), 0));
    // Arithmetic boundaries.
    vecs.push_back(mkv("pc_wrap",      1, 32'hFFFF_FFFC, 0, 32'h0, 0, 1, o(1,1,32'h0,1,0,0), 0));
    vecs.push_back(mkv("pc_lowbits",   1, 32'h1233, 0, 32'h0,  0, 1, o(1,1,32'h1237,1,0,0), 0));
    // Reset in DRAIN drops the pending target; BOOT ignores PCSrc.
    vecs.push_back(mkv("redir_800",    1, 32'h1000, 1, 32'h800, 0, 0, o(1,0,0,0,1,0), 0));
    vecs.push_back(mkv("rst_in_drain", 0, 32'h1000, 0, 32'h0,   0, 0, o(0,0,RST_PC,0,0,0), 0));
    vecs.push_back(mkv("boot_ign_src", 1, 32'h1000, 1, 32'h900, 0, 1, o(0,1,RST_PC,0,0,0), 0));
    vecs.push_back(mkv("after_rst",    1, 32'h0,    0, 32'h0,   0, 1, o(1,1,32'h4,1,0,0), 0));
    // Timeout: 15 REQ cycles without ACK; a redirect in the last one loses.
    for (int i = 1; i < int'(TO); i++)
      vecs.push_back(mkv($sformatf("to_wait%0d", i), 1, 32'h4, 0, 32'h0, 0, 0, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("to_last_src",  1, 32'h4, 1, 32'hA00, 0, 0, o(1,0,0,0,0,0), 0));
    vecs.push_back(mkv("error_state",  1, 32'h4, 1, 32'hB00, 0, 1, o(0,0,0,0,0,1), 0));
    vecs.push_back(mkv("error_sticky", 1, 32'h4, 0, 32'h0,   0, 1, o(0,0,0,0,0,1), 0));
    vecs.push_back(mkv("error_rst",    0, 32'h4, 0, 32'h0,   0, 0, o(0,0,RST_PC,0,0,0), 0));

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Hand sequence: count REQ cycles until FETCH_ERR with ACK held low.
    @(posedge CLK);
    #1;
    RST = 1'b1; IMEM_ACK = 1'b0; EX_MEM_PCSrc = 1'b0; ID_STALL = 1'b0;
    exp_q.push_back(int'(TO));
    req_cycles = 0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (FETCH_ERR === 1'b1) begin
        hit = 1'b1;
        break;
      end
      if (IMEM_REQ === 1'b1) req_cycles++;
    end
    check_val("timeout_reached", int'(hit), 1);
    check_val("timeout_req_cycles", req_cycles, exp_q.pop_front());
    check_val("error_req_low", int'(IMEM_REQ), 0);

    // ERROR ignores ACK and redirects for several cycles.
    @(posedge CLK);
    #1;
    IMEM_ACK = 1'b1; EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'hC00;
    repeat (3) @(negedge CLK);
    check_val("error_hold_err", int'(FETCH_ERR), 1);
    check_val("error_hold_we", int'(PC_WE), 0);

    // Mid-cycle reset clears outputs before the next clock edge.
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_val("async_rst_err", int'(FETCH_ERR), 0);
    check_val("async_rst_we", int'(PC_WE), 0);
    check_val("async_rst_next", int'(PC_NEXT === RST_PC), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
